// File: rtl/immediate_generator_pkg.sv
// imm_pkg: shared widths, opcode classes and the opcode-to-immediate-kind mapping.
package imm_pkg;
  localparam int WIDTH = 16;
  localparam int OPC_W = 5;
  localparam logic [OPC_W-1:0] OPC_SE11 = 5'h00;
  localparam logic [OPC_W-1:0] OPC_SE3  = 5'h08;
  localparam logic [OPC_W-1:0] OPC_ZE11 = 5'h10;
  localparam logic [OPC_W-1:0] OPC_BR   = 5'h18;
  localparam logic [OPC_W-1:0] OPC_LUI  = 5'h1C;
  localparam logic [OPC_W-1:0] OPC_ME   = 5'h1D;
  localparam logic [OPC_W-1:0] OPC_NONE = 5'h1E;
  typedef enum logic [2:0] {
    K_SE11,
    K_SE3,
    K_ZE11,
    K_BR,
    K_LUI,
    K_ME,
    K_NONE
  } imm_kind_t;
  // The top two opcode bits select an 8-opcode class; the last class is split further.
  function automatic imm_kind_t opc_to_kind(input logic [OPC_W-1:0] opc);
    return opc[4:3] == OPC_SE11[4:3] ? K_SE11 :
           opc[4:3] == OPC_SE3[4:3]  ? K_SE3  :
           opc[4:3] == OPC_ZE11[4:3] ? K_ZE11 :
           opc[2:2] == OPC_BR[2:2]   ? K_BR   :
           opc == OPC_LUI            ? K_LUI  :
           opc == OPC_ME             ? K_ME   : K_NONE;
  endfunction
endpackage

// File: rtl/immediate_generator_decode.sv
// imm_class_decode: classifies the opcode field into an immediate kind.
module imm_class_decode
  import imm_pkg::*;
(
  input  logic [OPC_W-1:0] opc,
  output imm_kind_t        kind
);
  assign kind = opc_to_kind(opc);
endmodule

// File: rtl/immediate_generator.sv
// immediate_generator: combinational immediate mux plus the LUI upper-byte latch for LUI/ME pairs.
module immediate_generator
  import imm_pkg::*;
(
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] Input,
  output logic [WIDTH-1:0] Output
);
  logic [OPC_W-1:0] opc;
  logic [7:0]       upper_reg;
  logic [WIDTH-1:0] se11, se3, ze11, br, lui, me;
  imm_kind_t        kind;
  assign opc = Input[OPC_W-1:0];
  imm_class_decode u_decode (
    .opc (opc),
    .kind(kind)
  );
  // An unknown opcode never matches LUI, so X on Input leaves the byte untouched.
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) upper_reg <= 8'h00;
    else if (opc == OPC_LUI) upper_reg <= Input[12:5];
  always_comb begin
    se11   = {{5{Input[15]}}, Input[15:5]};
    se3    = {{13{Input[7]}}, Input[7:5]};
    ze11   = {5'b0, Input[15:5]};
    br     = {se11[WIDTH-2:0], 1'b0};
    lui    = {Input[12:5], 8'h00};
    me     = {upper_reg, Input[12:5]};
    Output = kind == K_SE11 ? se11 :
             kind == K_SE3  ? se3  :
             kind == K_ZE11 ? ze11 :
             kind == K_BR   ? br   :
             kind == K_LUI  ? lui  :
             kind == K_ME   ? me   : '0;
  end
endmodule

// File: tb/tb_immediate_generator.sv
// tb_immediate_generator: directed vectors with a queued scoreboard checked by a separate monitor.
module tb_immediate_generator;
  typedef struct {
    string       name;
    logic [15:0] exp;
  } exp_t;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [15:0] Input = 16'h0000;
  logic [15:0] Output;
  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  immediate_generator dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .Input (Input),
    .Output(Output)
  );
  always #5 CLK = ~CLK;
  function automatic logic [15:0] ins(input logic [4:0] opc, input logic [10:0] f);
    return {f, opc};
  endfunction
  task automatic apply(input string n, input logic [15:0] i, input logic [15:0] e);
    @(negedge CLK);
    Input = i;
    q.push_back('{n, e});
  endtask
  // Monitor: the vector driven at a falling edge is stable 2ns later.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        if (Output !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, Output, e.exp);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    // Decoding continues while reset is held; ME sees a cleared upper byte and LUI cannot load.
    apply("rst_se11", 16'h7FE0, 16'h03FF);
    apply("rst_lui", ins(5'h1C, 11'h0AB), 16'hAB00);
    apply("rst_me", ins(5'h1D, 11'h0CD), 16'h00CD);
    @(negedge CLK);
    RST_N = 1'b1;
    apply("me_no_lui", ins(5'h1D, 11'h0CD), 16'h00CD);
    apply("se3_neg4", 16'h0088, 16'hFFFC);
    apply("se3_pos3", 16'h0068, 16'h0003);
    apply("se3_hi_ignored", 16'hFF6F, 16'h0003);
    apply("se11_m1", 16'hFFE0, 16'hFFFF);
    apply("se11_max", 16'h7FE0, 16'h03FF);
    apply("se11_min", 16'h8000, 16'hFC00);
    apply("ze11_max", 16'hFFF0, 16'h07FF);
    apply("ze11_opc17", ins(5'h17, 11'h400), 16'h0400);
    apply("br_7ff", ins(5'h18, 11'h7FF), 16'hFFFE);
    apply("br_005", ins(5'h18, 11'h005), 16'h000A);
    apply("br_400", ins(5'h1B, 11'h400), 16'hF800);
    apply("lui_ab", ins(5'h1C, 11'h7AB), 16'hAB00);
    apply("me_abcd", ins(5'h1D, 11'h7CD), 16'hABCD);
    apply("me_hold", ins(5'h1D, 11'h012), 16'hAB12);
    apply("lui_12", ins(5'h1C, 11'h012), 16'h1200);
    apply("lui_34", ins(5'h1C, 11'h034), 16'h3400);
    apply("me_last_lui", ins(5'h1D, 11'h056), 16'h3456);
    apply("lui_ab2", ins(5'h1C, 11'h0AB), 16'hAB00);
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1 RST_N = 1'b1;
    apply("me_after_rst", ins(5'h1D, 11'h0CD), 16'h00CD);
    apply("lui_5a", ins(5'h1C, 11'h05A), 16'h5A00);
    apply("none_1e", 16'hFFFE, 16'h0000);
    apply("none_1f", 16'hFFFF, 16'h0000);
    apply("none_1e_lo", 16'h001E, 16'h0000);
    apply("me_after_none", ins(5'h1D, 11'h03C), 16'h5A3C);
    repeat (3) @(negedge CLK);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
